uart_tx_fifo: RTL
=================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line rate in bit/s; DIV = round(CLK_FREQ/BAUD), DIV >= 4.
REQ-003 SHALL have parameter DATA_BITS, default 8, payload width, legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop-bit count, legal values 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, entry count, power of two, >= 2.
REQ-007 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-008 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port tx_data  input  DATA_BITS  word to transmit, LSB first on line.
REQ-010 SHALL have port tx_valid  input  1  tx_data valid this cycle.
REQ-011 SHALL have port tx_ready  output  1  FIFO can accept a word; transfer occurs when tx_valid && tx_ready at a rising edge.
REQ-012 SHALL have port uart_tx  output  1  serial line, idle high.
REQ-013 SHALL have port tx_busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-014 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-015 SHALL buffer accepted words in a FIFO_DEPTH-entry FIFO; tx_ready = (fifo_count != FIFO_DEPTH), derived from registered state only.
REQ-016 SHALL ignore tx_valid when tx_ready is low; no entry is overwritten, fifo_count is unchanged.
REQ-017 SHALL, on a same-cycle push and pop, keep fifo_count unchanged; read/write pointers wrap modulo FIFO_DEPTH.
REQ-018 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-019 SHALL, in IDLE with FIFO non-empty, pop the head word, load the shift register, and enter START on the next edge.
REQ-020 SHALL hold each line bit for exactly DIV clk cycles, driven by a baud counter that restarts at 0 on entry to START.
REQ-021 SHALL drive uart_tx: START 0; DATA bits 0..DATA_BITS-1 in order; PARITY the odd/even parity bit (state skipped when PARITY=0); STOP 1 for STOP_BITS*DIV cycles.
REQ-022 SHALL compute parity over the DATA_BITS payload: even mode gives XOR of the bits, odd mode gives its inverse.
REQ-023 SHALL, at the end of STOP with FIFO non-empty, go directly to START with no idle bit between frames; otherwise return to IDLE.
REQ-024 SHALL produce a falling uart_tx edge 2 cycles after a word is accepted into an empty FIFO while in IDLE.
REQ-025 SHALL register uart_tx (no combinational path from any input to uart_tx).
REQ-026 SHALL keep the parameter set fixed at elaboration; no runtime reconfiguration.

Reset
REQ-027 SHALL, on rst high, asynchronously force: FSM IDLE, uart_tx 1, tx_busy 0, fifo_count 0, FIFO pointers 0, baud and bit counters 0.
REQ-028 SHALL, if reset occurs mid-frame, abort the frame, return the line high immediately, and discard all FIFO contents.
REQ-029 SHALL assert tx_ready in the first cycle after rst deasserts.

Structure
REQ-030 SHALL place parity-mode constants (PAR_NONE, PAR_ODD, PAR_EVEN) and the FSM state enum in shared package uart_pkg, for reuse by the matching receiver.
REQ-031 SHALL instantiate one sub-module, uart_baud_gen (parameter DIV; inputs clk, rst, en; output tick pulsing once per DIV cycles while en), shared with the receiver.
REQ-032 SHALL implement the FIFO inline as a register array with pointers and counter; no vendor IP.

Verification
REQ-033 SHALL cover 8N1 at 50 MHz/115200 (DIV=434): push 0x55 -> line 0,1,0,1,0,1,0,1,0,1 each 434 cycles; frame 4340 cycles; tx_busy clears after the frame.
REQ-034 SHALL cover PARITY=2, push 0x07 -> parity bit 1; PARITY=1, push 0x07 -> parity bit 0; DATA_BITS=7, push 0x41 -> 7 data bits then parity.
REQ-035 SHALL cover FIFO_DEPTH=4, push 6 words back-to-back -> tx_ready low once count hits 4 with first frame started; all 5 accepted words sent in order with zero idle gap; the rejected word is never sent.
REQ-036 SHALL cover STOP_BITS=2 -> stop high for 868 cycles before the next start bit.
REQ-037 SHALL cover rst asserted during DATA bit 3 -> uart_tx 1 and fifo_count 0 immediately; next accepted word produces a full clean frame.
REQ-038 SHALL cover push and pop on the same cycle at fifo_count 2 -> fifo_count remains 2.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and the matching receiver.
//
// Contents:
//   PAR_NONE / PAR_ODD / PAR_EVEN : parity-mode codes for the PARITY parameter
//   uart_state_e                  : frame FSM states
//   calc_div()                    : rounded clock-cycles-per-bit divisor
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Round to nearest rather than truncate so the bit period error stays
    // within half a clock cycle.
    function automatic int calc_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud-rate tick generator shared by the UART transmitter and receiver.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   en   : count while high; the counter is held at 0 while low
//   tick : one-cycle pulse on the last cycle of every DIV-cycle bit period
module uart_baud_gen #(
    parameter int DIV = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Holding the counter at 0 while disabled means the first bit after
    // enable is a full DIV cycles long.
    always_comb begin
        cnt_d = '0;
        if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO.
//
// Words pushed with a valid/ready handshake are queued and sent LSB first
// as start bit, DATA_BITS data bits, optional parity bit and STOP_BITS stop
// bits. Back-to-back frames are sent with no idle time between them.
//
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset (aborts frame, empties FIFO)
//   tx_data    : word to transmit
//   tx_valid   : tx_data valid this cycle
//   tx_ready   : FIFO has room; transfer when tx_valid && tx_ready
//   uart_tx    : registered serial line, idle high
//   tx_busy    : frame on the line or words still queued
//   fifo_count : current FIFO occupancy
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;

    // Frame engine
    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 uart_tx_q, uart_tx_d;
    logic                 tx_busy_q, tx_busy_d;

    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    logic                 tick;
    logic [DATA_BITS-1:0] head;

    assign tx_ready   = (count_q != CW'(FIFO_DEPTH));
    assign push       = tx_valid && tx_ready;
    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];

    uart_baud_gen #(
        .DIV (DIV)
    ) u_baud_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q != ST_IDLE),
        .tick (tick)
    );

    // FIFO next state; pointers wrap naturally because the depth is a
    // power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = tx_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Frame FSM. The parity bit is computed once when the word is loaded,
    // and the next word is popped at the end of the stop period so frames
    // follow each other without an idle bit.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        par_d     = par_q;
        bit_cnt_d = bit_cnt_q;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    par_d   = (PARITY == PAR_ODD) ? ~(^head) : (^head);
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    bit_cnt_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    bit_cnt_d = '0;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        bit_cnt_d = '0;
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shift_d = head;
                            par_d   = (PARITY == PAR_ODD) ? ~(^head) : (^head);
                            state_d = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level is decoded from the current state and then registered, so
    // the line trails the FSM by one cycle and no input reaches uart_tx
    // combinationally.
    always_comb begin
        uart_tx_d = 1'b1;
        case (state_q)
            ST_START:  uart_tx_d = 1'b0;
            ST_DATA:   uart_tx_d = shift_q[0];
            ST_PARITY: uart_tx_d = par_q;
            default:   uart_tx_d = 1'b1;
        endcase
        tx_busy_d = (state_q != ST_IDLE) || !fifo_empty;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            par_q     <= 1'b0;
            bit_cnt_q <= '0;
            uart_tx_q <= 1'b1;
            tx_busy_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            bit_cnt_q <= bit_cnt_d;
            uart_tx_q <= uart_tx_d;
            tx_busy_q <= tx_busy_d;
        end
    end

    assign uart_tx    = uart_tx_q;
    assign tx_busy    = tx_busy_q;
    assign fifo_count = count_q;

endmodule
